spi_stream_fifo: RTL

- Parametrised successor of the single-entry SPI byte buffer: a DEPTH-entry, DATA_W-wide valid/ready FIFO between the SPI shift engine and downstream byte consumers.
- Adds sustained one-word-per-cycle throughput, registered backpressure, fill level, almost-full flag, synchronous flush and a sticky overflow-attempt flag.
- Sits in the SpeedSPI datapath on both RX and TX sides; one instance per direction.

---
 rtl/spi_stream_fifo.sv | 85 ++++++++
 1 files changed

// File: rtl/spi_stream_fifo.sv
// rtl/spi_stream_fifo.sv - DEPTH-entry valid/ready word FIFO with registered outputs
// Sits between the SPI shift engine and byte consumers; one instance per direction.
module spi_stream_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic                       ovf
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic              push;
  logic              pop;
  logic [LW-1:0]     level_next;
  logic [PW-1:0]     rd_next;
  logic [DATA_W-1:0] head_next;

  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign level_next = level + LW'(push) - LW'(pop);
  assign rd_next    = rd_ptr + PW'(pop);
  // The new head is the word being written this edge only when nothing older remains.
  assign head_next  = (push && (rd_next == wr_ptr)) ? in_data : mem[rd_next];

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      almost_full <= 1'b0;
      ovf         <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      almost_full <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr      <= rd_next;
      level       <= level_next;
      in_ready    <= (level_next < LW'(DEPTH));
      out_valid   <= (level_next != '0);
      almost_full <= (level_next >= LW'(AFULL_LVL));
      if (in_valid && !in_ready) begin
        ovf <= 1'b1;
      end
      // Empty: out_data keeps its last value.
      if (level_next != '0) begin
        out_data <= head_next;
      end
    end
  end

endmodule
